pid_mul_sequencer: RTL and testbench

- Fan-control PID sequencer. Computes error, integral and derivative terms from setpoint and measured speed.
- Time-shares one external sequential signed multiplier (start/done strobe handshake, 2N-bit signed operands and result) for the Kp·e, Ki·i and Kd·d products.
- Accumulates the three products with saturation and emits an N-bit duty command to the PWM stage.

---
 rtl/pid_mul_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_pid_mul_sequencer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/pid_mul_sequencer.sv
// pid_mul_sequencer
//   Fan-control PID iteration sequencer. On each sample request it forms the
//   error, integral and derivative terms, runs the three coefficient products
//   through one shared external sequential multiplier, accumulates them with
//   saturation and registers an unsigned duty command for the PWM stage.
//
// Ports
//   clk_i, rstn_i        clock, asynchronous active-low reset
//   sample_strb_i        start one control iteration (ignored while busy)
//   setpoint_i/actual_i  unsigned target / measured speed (N bits)
//   mul_start_strb_o     one-cycle start to the multiplier
//   mul_a_o / mul_b_o    signed coefficient / term operands (2N bits)
//   mul_done_strb_i      multiplier completion, mul_out_i valid with it
//   duty_o               registered unsigned duty command (N bits)
//   done_strb_o          duty_o updated this cycle
//   timeout_strb_o       iteration aborted, multiplier never answered
//   busy_o               sequencer not idle
//
// state  | meaning
// IDLE   | waiting for sample_strb_i
// LATCH  | form e, i_new, d; clear accumulator
// MUL_P  | start Kp*e
// WAIT_P | wait for Kp*e product
// MUL_I  | start Ki*i_new
// WAIT_I | wait for Ki*i_new product
// MUL_D  | start Kd*d
// WAIT_D | wait for Kd*d product, load duty on completion
// OUTPUT | pulse done, commit integral and previous error
module pid_mul_sequencer #(
  parameter int                    N       = 4,
  parameter logic signed [2*N-1:0] KP      = (2*N)'(2),
  parameter logic signed [2*N-1:0] KI      = (2*N)'(1),
  parameter logic signed [2*N-1:0] KD      = (2*N)'(1),
  parameter int                    TIMEOUT = 1023
) (
  input  logic           clk_i,
  input  logic           rstn_i,
  input  logic           sample_strb_i,
  input  logic [N-1:0]   setpoint_i,
  input  logic [N-1:0]   actual_i,
  output logic           mul_start_strb_o,
  output logic [2*N-1:0] mul_a_o,
  output logic [2*N-1:0] mul_b_o,
  input  logic           mul_done_strb_i,
  input  logic [2*N-1:0] mul_out_i,
  output logic [N-1:0]   duty_o,
  output logic           done_strb_o,
  output logic           timeout_strb_o,
  output logic           busy_o
);

  localparam int W  = 2 * N;
  localparam int CW = $clog2(TIMEOUT + 1);

  localparam logic signed [W:0] SAT_MAX = {2'b00, {(W-1){1'b1}}};
  localparam logic signed [W:0] SAT_MIN = {2'b11, {(W-1){1'b0}}};

  typedef enum logic [3:0] {
    IDLE, LATCH, MUL_P, WAIT_P, MUL_I, WAIT_I, MUL_D, WAIT_D, OUTPUT
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    e_q, e_d;
  logic [W-1:0]    i_new_q, i_new_d;
  logic [W-1:0]    d_q, d_d;
  logic [W-1:0]    integral_q, integral_d;
  logic [W-1:0]    e_prev_q, e_prev_d;
  logic [W-1:0]    sum_q, sum_d;
  logic [N-1:0]    duty_q, duty_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            timeout_q, timeout_d;
  logic            mul_start;
  logic            done_strb;
  logic [W-1:0]    mul_a, mul_b;
  logic [W-1:0]    e_calc;

  // Operands are sign-extended to W+1 bits so the clamp sees the true result.
  function automatic logic [W-1:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic sub);
    logic signed [W:0] x;
    if (sub) x = $signed({a[W-1], a} - {b[W-1], b});
    else     x = $signed({a[W-1], a} + {b[W-1], b});
    if (x > SAT_MAX)      sat_add = SAT_MAX[W-1:0];
    else if (x < SAT_MIN) sat_add = SAT_MIN[W-1:0];
    else                  sat_add = x[W-1:0];
  endfunction

  function automatic logic [N-1:0] clamp_duty(input logic [W-1:0] s);
    if (s[W-1])           clamp_duty = '0;
    else if (|s[W-2:N])   clamp_duty = '1;
    else                  clamp_duty = s[N-1:0];
  endfunction

  // Difference of two unsigned N-bit values always fits in W signed bits.
  assign e_calc = {{N{1'b0}}, setpoint_i} - {{N{1'b0}}, actual_i};

  always_comb begin
    state_d    = state_q;
    e_d        = e_q;
    i_new_d    = i_new_q;
    d_d        = d_q;
    integral_d = integral_q;
    e_prev_d   = e_prev_q;
    sum_d      = sum_q;
    duty_d     = duty_q;
    cnt_d      = cnt_q;
    timeout_d  = 1'b0;
    mul_start  = 1'b0;
    done_strb  = 1'b0;
    mul_a      = '0;
    mul_b      = '0;

    // Operands stay on the bus from the start cycle through the wait.
    case (state_q)
      MUL_P, WAIT_P: begin mul_a = KP; mul_b = e_q;     end
      MUL_I, WAIT_I: begin mul_a = KI; mul_b = i_new_q; end
      MUL_D, WAIT_D: begin mul_a = KD; mul_b = d_q;     end
      default: ;
    endcase

    case (state_q)
      IDLE: if (sample_strb_i) state_d = LATCH;
      LATCH: begin
        e_d     = e_calc;
        i_new_d = sat_add(integral_q, e_calc, 1'b0);
        d_d     = sat_add(e_calc, e_prev_q, 1'b1);
        sum_d   = '0;
        state_d = MUL_P;
      end
      MUL_P, MUL_I, MUL_D: begin
        mul_start = 1'b1;
        cnt_d     = '0;
        state_d   = (state_q == MUL_P) ? WAIT_P : (state_q == MUL_I) ? WAIT_I : WAIT_D;
      end
      WAIT_P, WAIT_I, WAIT_D: begin
        cnt_d = cnt_q + 1'b1;
        // A done arriving on the final count still completes the product.
        if (mul_done_strb_i) begin
          sum_d = sat_add(sum_q, mul_out_i, 1'b0);
          if (state_q == WAIT_P)      state_d = MUL_I;
          else if (state_q == WAIT_I) state_d = MUL_D;
          else begin
            duty_d  = clamp_duty(sum_d);
            state_d = OUTPUT;
          end
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          timeout_d = 1'b1;
          state_d   = IDLE;
        end
      end
      OUTPUT: begin
        done_strb  = 1'b1;
        integral_d = i_new_q;
        e_prev_d   = e_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q    <= IDLE;
      e_q        <= '0;
      i_new_q    <= '0;
      d_q        <= '0;
      integral_q <= '0;
      e_prev_q   <= '0;
      sum_q      <= '0;
      duty_q     <= '0;
      cnt_q      <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      e_q        <= e_d;
      i_new_q    <= i_new_d;
      d_q        <= d_d;
      integral_q <= integral_d;
      e_prev_q   <= e_prev_d;
      sum_q      <= sum_d;
      duty_q     <= duty_d;
      cnt_q      <= cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign mul_start_strb_o = mul_start;
  assign mul_a_o          = mul_a;
  assign mul_b_o          = mul_b;
  assign duty_o           = duty_q;
  assign done_strb_o      = done_strb;
  assign timeout_strb_o   = timeout_q;
  assign busy_o           = (state_q != IDLE);

endmodule

// File: tb/tb_pid_mul_sequencer.sv
module tb_pid_mul_sequencer;

  logic       clk = 1'b0;
  logic       rstn;
  logic       sample;
  logic [3:0] sp, act;
  logic       mul_start;
  logic [7:0] mul_a, mul_b;
  logic       mul_done = 1'b0;
  logic [7:0] mul_out = '0;
  logic [3:0] duty;
  logic       done_strb, timeout_strb, busy;

  pid_mul_sequencer dut (
    .clk_i(clk), .rstn_i(rstn), .sample_strb_i(sample),
    .setpoint_i(sp), .actual_i(act),
    .mul_start_strb_o(mul_start), .mul_a_o(mul_a), .mul_b_o(mul_b),
    .mul_done_strb_i(mul_done), .mul_out_i(mul_out),
    .duty_o(duty), .done_strb_o(done_strb), .timeout_strb_o(timeout_strb),
    .busy_o(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared = 0;
  int mismatched = 0;

  task automatic check(input string name, input int got, input int exp);
    compared++;
    if (got != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  typedef struct { logic [7:0] a; logic [7:0] b; } op_t;
  typedef struct { bit is_to; logic [3:0] duty; int start_cyc; } res_t;
  op_t  op_q[$];
  res_t res_q[$];

  // Bench multiplier: done in the 10th wait cycle after the start pulse.
  localparam int L = 10;
  bit         mul_en = 1'b1;
  int         rem = 0;
  logic [7:0] la, lb;
  always @(negedge clk) begin
    logic signed [15:0] p;
    if (!rstn) begin
      rem = 0;
      mul_done = 1'b0;
    end else begin
      mul_done = 1'b0;
      if (rem > 0) begin
        rem--;
        if (rem == 0) begin
          p = $signed(la) * $signed(lb);
          mul_out = p[7:0];
          mul_done = 1'b1;
        end
      end
      if (mul_start && mul_en) begin
        rem = L;
        la = mul_a;
        lb = mul_b;
      end
    end
  end

  // Monitor: pops expected operands on each start, expected results on each strobe.
  always @(negedge clk) begin
    op_t  o;
    res_t r;
    if (rstn) begin
      if (mul_start) begin
        if (op_q.size() == 0) check("unexpected_start", 1, 0);
        else begin
          o = op_q.pop_front();
          check("mul_a", int'(mul_a), int'(o.a));
          check("mul_b", int'(mul_b), int'(o.b));
        end
      end
      if (done_strb || timeout_strb) begin
        if (res_q.size() == 0) check("unexpected_result", 1, 0);
        else begin
          r = res_q.pop_front();
          check("result_kind_timeout", int'(timeout_strb), int'(r.is_to));
          check("duty", int'(duty), int'(r.duty));
          check("latency", cyc - r.start_cyc, r.is_to ? 1026 : 35);
          if (timeout_strb) check("busy_at_timeout", int'(busy), 0);
        end
      end
    end
  end

  logic [7:0] coef [3] = '{8'd2, 8'd1, 8'd1};

  task automatic run_iter(input logic [3:0] s, input logic [3:0] a, input bit is_to,
                          input logic [3:0] exp_duty, input int nops,
                          input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                          input int pulse_at);
    logic [7:0] bs [3];
    res_t r;
    bit   fin;
    bs[0] = b0; bs[1] = b1; bs[2] = b2;
    for (int k = 0; k < nops; k++) op_q.push_back('{coef[k], bs[k]});
    @(negedge clk);
    sp = s; act = a; sample = 1'b1;
    r.is_to = is_to; r.duty = exp_duty; r.start_cyc = cyc;
    res_q.push_back(r);
    fin = 1'b0;
    for (int i = 1; i < 1500 && !fin; i++) begin
      @(negedge clk);
      sample = (i == pulse_at);
      if (i > 2 && !busy && !sample) fin = 1'b1;
    end
    if (!fin) check("iteration_timeout", 0, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0; sample = 1'b0; sp = '0; act = '0;
    #1;
    check("rst_busy", int'(busy), 0);
    check("rst_duty", int'(duty), 0);
    check("rst_start", int'(mul_start), 0);
    check("rst_done", int'(done_strb), 0);
    check("rst_timeout", int'(timeout_strb), 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // Positive step and follow-on samples.
    run_iter(4'd10, 4'd4, 0, 4'd15, 3, 8'd6, 8'd6, 8'd6, 0);
    run_iter(4'd4,  4'd4, 0, 4'd0,  3, 8'd0, 8'd6, 8'hFA, 0);
    run_iter(4'd5,  4'd4, 0, 4'd10, 3, 8'd1, 8'd7, 8'd1, 0);

    // Multiplier never answers; extra sample during busy is ignored.
    mul_en = 1'b0;
    run_iter(4'd15, 4'd0, 1, 4'd10, 1, 8'd15, 8'd0, 8'd0, 50);
    mul_en = 1'b1;
    check("idle_after_timeout", int'(busy), 0);
    // Integral stays 7 and e_prev stays 1 after the discarded iteration.
    run_iter(4'd5, 4'd4, 0, 4'd10, 3, 8'd1, 8'd8, 8'd0, 0);

    // Reset while waiting for the Ki product.
    op_q.push_back('{8'd2, 8'd15});
    op_q.push_back('{8'd1, 8'd23});
    @(negedge clk);
    sp = 4'd15; act = 4'd0; sample = 1'b1;
    @(negedge clk);
    sample = 1'b0;
    repeat (18) @(negedge clk);
    check("in_wait_i_busy", int'(busy), 1);
    rstn = 1'b0;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_duty", int'(duty), 0);
    check("midrst_start", int'(mul_start), 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    check("ops_after_midrst", op_q.size(), 0);

    // Negative clamp with cleared integral and e_prev.
    run_iter(4'd0, 4'd15, 0, 4'd0, 3, 8'hF1, 8'hF1, 8'hF1, 0);

    // Integral saturation.
    do_reset();
    for (int k = 1; k <= 9; k++) begin
      run_iter(4'd15, 4'd0, 0, 4'd15, 3, 8'd15,
               (15 * k > 127) ? 8'd127 : 8'(15 * k),
               (k == 1) ? 8'd15 : 8'd0, 0);
    end

    repeat (20) @(negedge clk);
    check("ops_left", op_q.size(), 0);
    check("results_left", res_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
